// File: rtl/reflect_slot_scheduler_if.sv
// Scheduler-to-modulator handshake plus the reflector enable window.
// The scheduler is the master; the bit modulator is the slave.
interface reflect_slot_scheduler_if;
    logic mod_req;
    logic mod_ack;
    logic mod_done;
    logic reflect_gate;

    modport master (
        output mod_req,
        output reflect_gate,
        input  mod_ack,
        input  mod_done
    );

    modport slave (
        input  mod_req,
        input  reflect_gate,
        output mod_ack,
        output mod_done
    );
endinterface

// File: rtl/reflect_slot_scheduler.sv
// Turns each trigger rising edge into one reflection slot: fixed delay, slot offset
// (fixed or LFSR-random), then a req/ack/done grant of the reflector to the modulator.
module reflect_slot_scheduler #(
    parameter int          CLK_FREQ_MHZ           = 50,
    parameter int          TRIG_DELAY_IN_US       = 2,
    parameter int          TRIG_DELAY_IN_20NS_NEG = 35,
    parameter logic [15:0] MAC_SEED               = 16'h7654,
    parameter int          SLOT_LEN_CYCLES        = 500,
    parameter int          GUARD_CYCLES           = 50
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            trig,
    input  logic [1:0]                      mode,
    input  logic [1:0]                      mac_q,
    reflect_slot_scheduler_if.master        mod_if,
    output logic [2:0]                      slot_idx,
    output logic                            busy,
    output logic [7:0]                      overrun_cnt,
    output logic [7:0]                      timeout_cnt
);
    localparam int D_RAW    = TRIG_DELAY_IN_US * CLK_FREQ_MHZ - TRIG_DELAY_IN_20NS_NEG;
    localparam int D        = (D_RAW < 1) ? 1 : D_RAW;
    localparam int WAIT_MAX = D + 7 * SLOT_LEN_CYCLES;
    localparam int CNT_MAX  = (WAIT_MAX > GUARD_CYCLES) ? WAIT_MAX : GUARD_CYCLES;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    // The shared counter holds "cycles left minus one" for the current state.
    localparam logic [CNT_W-1:0] D_LAST     = CNT_W'(D - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_LEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_LEN_W = CNT_W'(SLOT_LEN_CYCLES);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [15:0]      LFSR_TAPS  = 16'hB400;

    localparam logic [1:0] MODE_FIXED = 2'b01;
    localparam logic [1:0] MODE_RAND  = 2'b10;
    localparam logic [1:0] MODE_CONT  = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_REQ, S_ACTIVE, S_GUARD} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [2:0]       slot_idx_q, slot_idx_d;
    logic [7:0]       overrun_q, overrun_d;
    logic [7:0]       timeout_q, timeout_d;
    logic             gate_q, gate_d;
    logic             done_pend_q, done_pend_d;
    logic             trig_q;
    logic             trig_edge;
    logic             timeout_hit;

    assign trig_edge = trig & ~trig_q;
    assign lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin : state_reg
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin : data_reg
        if (!reset) begin
            cnt_q       <= '0;
            lfsr_q      <= MAC_SEED;
            slot_idx_q  <= 3'd0;
            overrun_q   <= 8'd0;
            timeout_q   <= 8'd0;
            gate_q      <= 1'b0;
            done_pend_q <= 1'b0;
            trig_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            lfsr_q      <= lfsr_d;
            slot_idx_q  <= slot_idx_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
            gate_q      <= gate_d;
            done_pend_q <= done_pend_d;
            trig_q      <= trig;
        end
    end

    always_comb begin : next_state
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        slot_idx_d  = slot_idx_q;
        done_pend_d = done_pend_q;
        overrun_d   = overrun_q;
        timeout_d   = timeout_q;
        timeout_hit = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (trig_edge && (mode == MODE_FIXED || mode == MODE_RAND)) begin
                    slot_idx_d = (mode == MODE_RAND) ? (lfsr_q[2:0] & 3'((4'd1 << mac_q) - 4'd1))
                                                     : 3'd0;
                    cnt_d      = D_LAST + CNT_W'(slot_idx_d) * SLOT_LEN_W;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_REQ;
                    cnt_d   = SLOT_LAST;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_REQ: begin
                // A done arriving with the ack is remembered so ACTIVE lasts one cycle.
                if (mod_if.mod_ack) begin
                    state_d     = S_ACTIVE;
                    cnt_d       = SLOT_LAST;
                    done_pend_d = mod_if.mod_done;
                end else if (cnt_q == '0) begin
                    state_d     = S_GUARD;
                    cnt_d       = GUARD_LAST;
                    timeout_hit = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_ACTIVE: begin
                if (mod_if.mod_done || done_pend_q) begin
                    state_d     = S_GUARD;
                    cnt_d       = GUARD_LAST;
                    done_pend_d = 1'b0;
                end else if (cnt_q == '0) begin
                    state_d     = S_GUARD;
                    cnt_d       = GUARD_LAST;
                    timeout_hit = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_GUARD: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (timeout_hit && timeout_q != 8'hFF)
            timeout_d = timeout_q + 8'd1;
        if (trig_edge && state_q != S_IDLE && overrun_q != 8'hFF)
            overrun_d = overrun_q + 8'd1;

        // Registered gate: continuous mode follows mode one cycle late, ACTIVE starts after ack.
        gate_d = (state_d == S_ACTIVE) || (state_d == S_IDLE && mode == MODE_CONT);
    end

    always_comb begin : outputs
        mod_if.mod_req = (state_q == S_REQ);
        busy           = (state_q != S_IDLE);
    end

    assign mod_if.reflect_gate = gate_q;
    assign slot_idx            = slot_idx_q;
    assign overrun_cnt         = overrun_q;
    assign timeout_cnt         = timeout_q;
endmodule

// File: tb/tb_reflect_slot_scheduler.sv
// Randomized self-checking bench for reflect_slot_scheduler; expectations come from
// a timing/arithmetic model of the slot rules and a polynomial-level LFSR model.
module tb_reflect_slot_scheduler;
    localparam int          CLK_FREQ_MHZ = 50;
    localparam int          DLY_US       = 2;
    localparam int          DLY_NEG      = 35;
    localparam logic [15:0] SEED         = 16'h7654;
    localparam int          SLOT_LEN     = 500;
    localparam int          GUARD        = 50;
    localparam int          D            = (DLY_US * CLK_FREQ_MHZ - DLY_NEG < 1) ? 1
                                           : DLY_US * CLK_FREQ_MHZ - DLY_NEG;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       trig = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [1:0] mac_q = 2'b00;
    logic [2:0] slot_idx;
    logic       busy;
    logic [7:0] overrun_cnt;
    logic [7:0] timeout_cnt;

    reflect_slot_scheduler_if mod_if ();

    reflect_slot_scheduler #(
        .CLK_FREQ_MHZ          (CLK_FREQ_MHZ),
        .TRIG_DELAY_IN_US      (DLY_US),
        .TRIG_DELAY_IN_20NS_NEG(DLY_NEG),
        .MAC_SEED              (SEED),
        .SLOT_LEN_CYCLES       (SLOT_LEN),
        .GUARD_CYCLES          (GUARD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .trig       (trig),
        .mode       (mode),
        .mac_q      (mac_q),
        .mod_if     (mod_if.master),
        .slot_idx   (slot_idx),
        .busy       (busy),
        .overrun_cnt(overrun_cnt),
        .timeout_cnt(timeout_cnt)
    );

    always #10 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          exp_overrun = 0;
    int          exp_timeout = 0;
    logic [15:0] m_lfsr = SEED;

    // Galois LFSR built from the polynomial exponents x^16+x^14+x^13+x^11+1.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        int          exps[4] = '{16, 14, 13, 11};
        logic [15:0] taps = '0;
        for (int i = 0; i < 4; i++) taps[exps[i]-1] = 1'b1;
        return s[0] ? ((s >> 1) ^ taps) : (s >> 1);
    endfunction

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        m_lfsr <= reset ? lfsr_next(m_lfsr) : SEED;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sig_of(input int sel);
        case (sel)
            0:       return mod_if.mod_req;
            1:       return mod_if.reflect_gate;
            default: return busy;
        endcase
    endfunction

    task automatic wait_level(input string tag, input int sel, input logic lvl,
                              input int budget, output int at);
        int n = 0;
        while (sig_of(sel) !== lvl && n < budget) begin
            step();
            n++;
        end
        if (sig_of(sel) !== lvl) check({tag, "_bound"}, sig_of(sel), lvl);
        at = cyc;
    endtask

    // One-cycle trig pulse; e is the posedge at which the DUT sees the edge.
    task automatic fire_trig(output int e);
        trig = 1'b1;
        e    = cyc + 1;
        step();
        trig = 1'b0;
    endtask

    task automatic bump_overrun();
        if (exp_overrun < 255) exp_overrun++;
    endtask

    task automatic bump_timeout();
        if (exp_timeout < 255) exp_timeout++;
    endtask

    // ack_dly 0 = never ack; done_dly 0 = never done, -1 = done together with ack.
    task automatic txn(input logic [1:0] md, input logic [1:0] mq, input int ack_dly,
                       input int done_dly, input bit ovr_wait, input bit ovr_guard);
        int e, r, a, dn, t, exp_slot, exp_wait;
        bit gate_ok;
        mode     = md;
        mac_q    = mq;
        exp_slot = (md == 2'b10) ? (int'(m_lfsr[2:0]) % (1 << mq)) : 0;
        exp_wait = D + exp_slot * SLOT_LEN;
        fire_trig(e);
        check("slot_idx", slot_idx, exp_slot);
        check("busy_on", busy, 1);
        if (ovr_wait) begin
            step();
            fire_trig(t);
            bump_overrun();
        end
        wait_level("req_rise", 0, 1'b1, exp_wait + 10, r);
        check("req_delay", r - e, exp_wait);
        if (ack_dly == 0) begin
            wait_level("req_drop", 0, 1'b0, SLOT_LEN + 10, t);
            check("ack_timeout_len", t - r, SLOT_LEN);
            bump_timeout();
            dn = t;
        end else begin
            repeat (ack_dly - 1) step();
            check("req_hold", mod_if.mod_req, 1);
            mod_if.mod_ack = 1'b1;
            if (done_dly < 0) mod_if.mod_done = 1'b1;
            step();
            mod_if.mod_ack  = 1'b0;
            mod_if.mod_done = 1'b0;
            a = cyc;
            check("req_drop_after_ack", mod_if.mod_req, 0);
            check("gate_on_after_ack", mod_if.reflect_gate, 1);
            if (done_dly < 0) begin
                step();
                check("gate_off_ack_done", mod_if.reflect_gate, 0);
                dn = cyc;
            end else if (done_dly == 0) begin
                wait_level("gate_drop", 1, 1'b0, SLOT_LEN + 10, t);
                check("done_timeout_len", t - a, SLOT_LEN);
                bump_timeout();
                dn = t;
            end else begin
                gate_ok = 1'b1;
                repeat (done_dly - 1) begin
                    step();
                    if (mod_if.reflect_gate !== 1'b1) gate_ok = 1'b0;
                end
                mod_if.mod_done = 1'b1;
                step();
                mod_if.mod_done = 1'b0;
                dn = cyc;
                check("gate_hold", gate_ok, 1);
                check("gate_off_after_done", mod_if.reflect_gate, 0);
            end
        end
        check("busy_in_guard", busy, 1);
        if (ovr_guard) begin
            fire_trig(t);
            bump_overrun();
        end
        wait_level("busy_fall", 2, 1'b0, GUARD + 10, t);
        check("guard_len", t - dn, GUARD);
        check("slot_idx_held", slot_idx, exp_slot);
        check("overrun_cnt", overrun_cnt, exp_overrun);
        check("timeout_cnt", timeout_cnt, exp_timeout);
        repeat ($urandom_range(1, 20)) step();
    endtask

    initial begin
        int         e, t, r;
        logic [1:0] mq;
        int         ad, dd;
        mod_if.mod_ack  = 1'b0;
        mod_if.mod_done = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_gate", mod_if.reflect_gate, 0);
        check("rst_busy", busy, 0);
        reset = 1'b1;
        step();
        check("rel_req", mod_if.mod_req, 0);
        check("rel_gate", mod_if.reflect_gate, 0);
        check("rel_busy", busy, 0);
        check("rel_slot", slot_idx, 0);
        check("rel_overrun", overrun_cnt, 0);
        check("rel_timeout", timeout_cnt, 0);

        txn(2'b01, 2'd2, 3, 20, 1'b0, 1'b0);
        txn(2'b01, 2'd0, 2, 5, 1'b1, 1'b1);
        check("overrun_two", overrun_cnt, 2);

        for (int i = 0; i < 24; i++) begin
            mq = (i < 8) ? 2'd3 : (i < 12) ? 2'd0 : 2'($urandom_range(0, 3));
            ad = $urandom_range(1, 8);
            dd = ($urandom_range(0, 5) == 0) ? -1 : $urandom_range(1, 30);
            txn(2'b10, mq, ad, dd, 1'b0, 1'b0);
        end

        txn(2'b01, 2'd0, 0, 20, 1'b0, 1'b0);
        check("timeout_one", timeout_cnt, 1);
        txn(2'b01, 2'd0, 3, 0, 1'b0, 1'b0);
        check("timeout_two", timeout_cnt, 2);

        mode = 2'b11;
        step();
        check("m11_gate", mod_if.reflect_gate, 1);
        fire_trig(e);
        step();
        check("m11_busy", busy, 0);
        check("m11_gate_hold", mod_if.reflect_gate, 1);
        check("m11_overrun", overrun_cnt, exp_overrun);
        mode = 2'b00;
        step();
        check("m00_gate_drop", mod_if.reflect_gate, 0);
        fire_trig(e);
        step();
        check("m00_busy", busy, 0);

        mode = 2'b01;
        fire_trig(e);
        for (int i = 0; i < 300; i++) begin
            step();
            fire_trig(t);
            bump_overrun();
        end
        check("overrun_sat", overrun_cnt, exp_overrun);
        wait_level("sat_busy_fall", 2, 1'b0, 2 * SLOT_LEN, t);
        bump_timeout();
        check("sat_timeout", timeout_cnt, exp_timeout);
        repeat (5) step();

        fire_trig(e);
        wait_level("rst_req", 0, 1'b1, D + 10, r);
        mod_if.mod_ack = 1'b1;
        step();
        mod_if.mod_ack = 1'b0;
        check("rst_active_gate", mod_if.reflect_gate, 1);
        repeat (5) step();
        reset = 1'b0;
        step();
        exp_overrun = 0;
        exp_timeout = 0;
        check("midrst_gate", mod_if.reflect_gate, 0);
        check("midrst_busy", busy, 0);
        check("midrst_req", mod_if.mod_req, 0);
        check("midrst_overrun", overrun_cnt, 0);
        check("midrst_timeout", timeout_cnt, 0);
        reset = 1'b1;
        step();
        txn(2'b10, 2'd3, 2, 10, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #(20 * 95000);
        $display("FAIL watchdog: observed cycle %0d expected completion", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
